video_timing_gen: RTL

//  Display timing generator for the 1024x768 @60 Hz world-map display (65 MHz pixel clock).

---
 rtl/video_timing_gen.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : video_timing_gen                                             |
// | Description : Free-running raster timing generator for the 1024x768 @60 Hz |
// |               world-map display (65 MHz pixel clock). Produces registered  |
// |               pixel coordinates, horizontal/vertical sync, video_on and a  |
// |               one-clock frame_start pulse at coordinate (0,0).             |
// |               Optional macro DTG_SYNC_DELAY_EN: horiz_sync, vert_sync and  |
// |               video_on are retimed by SYNC_DELAY extra clocks to line up   |
// |               with the map ROM read latency behind the scaler.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module video_timing_gen #(
   parameter int unsigned H_ACTIVE   = 1024,
   parameter int unsigned H_FRONT    = 24,
   parameter int unsigned H_SYNC     = 136,
   parameter int unsigned H_BACK     = 160,
   parameter int unsigned V_ACTIVE   = 768,
   parameter int unsigned V_FRONT    = 3,
   parameter int unsigned V_SYNC     = 6,
   parameter int unsigned V_BACK     = 29,
   parameter logic        SYNC_POL   = 1'b0,
   parameter int unsigned SYNC_DELAY = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic [11:0] pixel_column,
   output logic [11:0] pixel_row,
   output logic        horiz_sync,
   output logic        vert_sync,
   output logic        video_on,
   output logic        frame_start
);

   // Raster geometry, all resolved at elaboration. Totals must not exceed 4096
   // so the 12-bit counters can hold every coordinate. Sync windows are held
   // at 13 bits so an end bound of exactly 4096 still compares correctly.
   localparam int unsigned c_h_total    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned c_v_total    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam logic [11:0] c_h_last     = 12'(c_h_total - 1);
   localparam logic [11:0] c_v_last     = 12'(c_v_total - 1);
   localparam logic [12:0] c_h_act      = 13'(H_ACTIVE);
   localparam logic [12:0] c_v_act      = 13'(V_ACTIVE);
   localparam logic [12:0] c_hs_start   = 13'(H_ACTIVE + H_FRONT);
   localparam logic [12:0] c_hs_end     = 13'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [12:0] c_vs_start   = 13'(V_ACTIVE + V_FRONT);
   localparam logic [12:0] c_vs_end     = 13'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic        c_sync_off   = ~SYNC_POL;

   logic [11:0] h_cnt_q, h_cnt_d;
   logic [11:0] v_cnt_q, v_cnt_d;
   logic [12:0] h_ext, v_ext;

   logic [11:0] col_q, col_d;
   logic [11:0] row_q, row_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        von_q, von_d;
   logic        fs_q, fs_d;

   assign h_ext = {1'b0, h_cnt_q};
   assign v_ext = {1'b0, v_cnt_q};

   // Raster counters: horizontal advances every clock, vertical on horizontal wrap.
   always_comb begin
      h_cnt_d = h_cnt_q + 12'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q >= c_h_last) begin
         h_cnt_d = '0;
         if (v_cnt_q >= c_v_last) begin
            v_cnt_d = '0;
         end else begin
            v_cnt_d = v_cnt_q + 12'd1;
         end
      end
   end

   // Decode of the current count; it lands in the output registers on the same
   // edge that advances the counters, so outputs describe the pre-advance count.
   always_comb begin
      col_d = h_cnt_q;
      row_d = v_cnt_q;
      hs_d  = c_sync_off;
      vs_d  = c_sync_off;
      if ((h_ext >= c_hs_start) && (h_ext < c_hs_end)) begin
         hs_d = SYNC_POL;
      end
      if ((v_ext >= c_vs_start) && (v_ext < c_vs_end)) begin
         vs_d = SYNC_POL;
      end
      von_d = (h_ext < c_h_act) && (v_ext < c_v_act);
      fs_d  = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
   end

   // Counter and output registers; reset parks syncs at their inactive level.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         col_q   <= '0;
         row_q   <= '0;
         hs_q    <= c_sync_off;
         vs_q    <= c_sync_off;
         von_q   <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         col_q   <= col_d;
         row_q   <= row_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         von_q   <= von_d;
         fs_q    <= fs_d;
      end
   end

   // Coordinates and frame_start are never retimed; the scaler needs them at
   // the raster position itself.
   assign pixel_column = col_q;
   assign pixel_row    = row_q;
   assign frame_start  = fs_q;

`ifdef DTG_SYNC_DELAY_EN
   generate
      if (SYNC_DELAY > 0) begin : g_sync_delay
         logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d;
         logic [SYNC_DELAY-1:0] vs_pipe_q, vs_pipe_d;
         logic [SYNC_DELAY-1:0] von_pipe_q, von_pipe_d;

         // Shift each retimed signal one stage deeper per clock.
         always_comb begin
            hs_pipe_d     = hs_pipe_q << 1;
            vs_pipe_d     = vs_pipe_q << 1;
            von_pipe_d    = von_pipe_q << 1;
            hs_pipe_d[0]  = hs_q;
            vs_pipe_d[0]  = vs_q;
            von_pipe_d[0] = von_q;
         end

         // Delay stages: syncs reset inactive, video_on resets blanked.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               hs_pipe_q  <= {SYNC_DELAY{c_sync_off}};
               vs_pipe_q  <= {SYNC_DELAY{c_sync_off}};
               von_pipe_q <= '0;
            end else begin
               hs_pipe_q  <= hs_pipe_d;
               vs_pipe_q  <= vs_pipe_d;
               von_pipe_q <= von_pipe_d;
            end
         end

         assign horiz_sync = hs_pipe_q[SYNC_DELAY-1];
         assign vert_sync  = vs_pipe_q[SYNC_DELAY-1];
         assign video_on   = von_pipe_q[SYNC_DELAY-1];
      end else begin : g_sync_direct
         assign horiz_sync = hs_q;
         assign vert_sync  = vs_q;
         assign video_on   = von_q;
      end
   endgenerate
`else
   // Without the retiming option every output shares the coordinate timing and
   // SYNC_DELAY has no effect.
   assign horiz_sync = hs_q;
   assign vert_sync  = vs_q;
   assign video_on   = von_q;

   generate
      if (SYNC_DELAY != 0) begin : g_sync_delay_ignored
      end
   endgenerate
`endif

endmodule
`default_nettype wire
